// File: rtl/multicycle_rv_pkg.sv
// Shared definitions for the multicycle RISC-V core: opcodes, FSM state
// encodings, ALU control and immediate extraction helpers.
// Imported by multicycle_rv_core.
package multicycle_rv_pkg;

  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_SD     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_EBREAK = 7'b1110011;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_HALT   = 3'd5;

  typedef enum logic [1:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr
  } alu_op_e;

  function automatic alu_op_e rtype_alu_op(input logic [2:0] funct3, input logic funct7_b5);
    case (funct3)
      3'b000:  return funct7_b5 ? AluSub : AluAdd;
      3'b111:  return AluAnd;
      3'b110:  return AluOr;
      default: return AluAdd;
    endcase
  endfunction

  // Immediates, sign-extended to 32 bits; the core widens them to XLEN.
  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/multicycle_rv_core_regfile.sv
// core_regfile: 32 x XLEN integer register file.
// Ports: clk_i; two combinational read ports (raddr_a_i/rdata_a_o,
// raddr_b_i/rdata_b_o); one synchronous write port (we_i, waddr_i, wdata_i).
// x0 always reads zero and ignores writes. Contents are not reset.
module core_regfile #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/multicycle_rv_core.sv
// multicycle_rv_core: XLEN-parametrised multicycle RISC-V integer core
// (add/sub/and/or, addi, ld, sd, beq, ebreak) with a unified memory port.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   mem_req/mem_we/mem_addr/mem_wdata (out), mem_rdata/mem_ready (in)
//                           - req/ready memory handshake, variable latency
//   halted, fault           - core stopped; stop caused by illegal op/misalignment
//   pc_out                  - current PC
// Optional: define MULTICYCLE_RV_CORE_PERF_EN to add cycle_cnt and
// instret_cnt (64-bit) performance counter outputs.
module multicycle_rv_core
  import multicycle_rv_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] pc_out
`ifdef MULTICYCLE_RV_CORE_PERF_EN
  ,
  output logic [63:0]       cycle_cnt,
  output logic [63:0]       instret_cnt
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, oldpc_q, oldpc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              fault_q, fault_d;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic            rf_we;
  logic [XLEN-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  assign rf_wdata = (opcode == OP_LD) ? mdr_q : alu_q;

  core_regfile #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk_i    (clock),
    .we_i     (rf_we),
    .waddr_i  (rd),
    .wdata_i  (rf_wdata),
    .raddr_a_i(rs1),
    .raddr_b_i(rs2),
    .rdata_a_o(rf_rdata_a),
    .rdata_b_o(rf_rdata_b)
  );

  // A 64-bit memory word holds two instructions; pc[2] picks the half.
  logic [31:0] instr;
  assign instr = (XLEN == 64 && pc_q[2]) ? mem_rdata[XLEN-1 -: 32] : mem_rdata[31:0];

  logic legal;
  always_comb begin
    case (opcode)
      OP_RTYPE: legal = ((funct3 == 3'b000) && ((funct7 == 7'b0000000) ||
                                                (funct7 == 7'b0100000))) ||
                        (((funct3 == 3'b111) || (funct3 == 3'b110)) && (funct7 == 7'b0000000));
      OP_ADDI:  legal = (funct3 == 3'b000);
      OP_LD:    legal = (funct3 == 3'b011);
      OP_SD:    legal = (funct3 == 3'b011);
      OP_BEQ:   legal = (funct3 == 3'b000);
      default:  legal = 1'b0;
    endcase
  end

  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_x, op_b, alu_res;
  alu_op_e           alu_op;
  logic              misaligned;
  logic [ADDR_W-1:0] br_target, pc_after_beq;

  always_comb begin
    imm32   = (opcode == OP_SD) ? imm_s(ir_q) : imm_i(ir_q);
    imm_x   = XLEN'(signed'(imm32));
    op_b    = (opcode == OP_RTYPE) ? b_q : imm_x;
    alu_op  = (opcode == OP_RTYPE) ? rtype_alu_op(funct3, funct7[5]) : AluAdd;
    alu_res = a_q + op_b;
    unique case (alu_op)
      AluAdd: alu_res = a_q + op_b;
      AluSub: alu_res = a_q - op_b;
      AluAnd: alu_res = a_q & op_b;
      AluOr:  alu_res = a_q | op_b;
      default: alu_res = a_q + op_b;
    endcase
    misaligned   = |(alu_res[2:0] & 3'(XLEN / 8 - 1));
    br_target    = oldpc_q + ADDR_W'(imm_b(ir_q));
    pc_after_beq = (a_q == b_q) ? br_target : pc_q;
  end

  // Memory outputs are registered: every transition into FETCH or MEM
  // launches its request on the same edge, so a request only takes a separate
  // cycle to launch right after reset.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    oldpc_d     = oldpc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fault_d     = fault_q;
    rf_we       = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem_ready) begin
          ir_d      = instr;
          oldpc_d   = pc_q;
          pc_d      = pc_q + ADDR_W'(4);
          mem_req_d = 1'b0;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d = rf_rdata_a;
        b_d = rf_rdata_b;
        if (opcode == OP_EBREAK) begin
          state_d = ST_HALT;
          fault_d = 1'b0;
        end else if (!legal) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: begin
            alu_d   = alu_res;
            state_d = ST_WB;
          end
          OP_LD, OP_SD: begin
            alu_d = alu_res;
            if (misaligned) begin
              state_d = ST_HALT;
              fault_d = 1'b1;
            end else begin
              state_d    = ST_MEM;
              mem_req_d  = 1'b1;
              mem_we_d   = (opcode == OP_SD);
              mem_addr_d = alu_res[ADDR_W-1:0];
              if (opcode == OP_SD) begin
                mem_wdata_d = b_q;
              end
            end
          end
          OP_BEQ: begin
            pc_d       = pc_after_beq;
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_after_beq;
          end
          default: begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LD) begin
            mdr_d     = mem_rdata;
            mem_req_d = 1'b0;
            state_d   = ST_WB;
          end else begin
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
          end
        end
      end
      ST_WB: begin
        rf_we      = 1'b1;
        state_d    = ST_FETCH;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = pc_q;
      end
      ST_HALT: begin
        mem_req_d = 1'b0;
      end
      default: begin
        state_d   = ST_HALT;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= ADDR_W'(RESET_PC);
      oldpc_q     <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      oldpc_q     <= oldpc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;
  assign pc_out    = pc_q;

`ifdef MULTICYCLE_RV_CORE_PERF_EN
  logic [63:0] cycle_cnt_q, instret_cnt_q;
  logic        retire;

  // Only WB, MEM(sd) and EXEC(beq) ever move into FETCH.
  assign retire = (state_q != ST_FETCH) && (state_d == ST_FETCH);

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != ST_HALT) begin
        cycle_cnt_q <= cycle_cnt_q + 64'd1;
      end
      if (retire) begin
        instret_cnt_q <= instret_cnt_q + 64'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
